always_ff_downtimer: RTL and testbench
======================================

ALWAYS_FF_DOWNTIMER -- requirements
Module: always_ff_downtimer

Interface
REQ-001 Parameter WIDTH, default 8: width of the count value.
REQ-002 Parameter PRE_W, default 4: width of the prescale input.
REQ-003 clk  input  1: single clock; all state changes on posedge clk.
REQ-004 reset_n  input  1: asynchronous, active-low reset; assertion immediately forces the reset state, independent of clk.
REQ-005 load  input  1: when high, load_val is written into the count.
REQ-006 load_val  input  WIDTH: count value to load.
REQ-007 prescale  input  PRE_W: one tick every prescale+1 clk cycles; sampled only at start.
REQ-008 start  input  1: request to begin counting down from the current count.
REQ-009 pause  input  1: level; while high in RUN, counting is frozen.
REQ-010 out  output  WIDTH: current count value, registered.
REQ-011 busy  output  1: high in RUN or PAUSE.
REQ-012 done  output  1: one-cycle pulse on expiry, registered.

Function
REQ-013 The block SHALL implement states IDLE, RUN and PAUSE, held in one state register.
REQ-014 Input priority SHALL be: reset_n, then load, then start, then pause.
REQ-015 In any state, load high SHALL set out to load_val on the next edge, enter IDLE, clear the prescale counter and suppress done.
REQ-016 In IDLE with start high and out != 0, the block SHALL enter RUN, latch prescale into an internal divisor register and clear the prescale counter.
REQ-017 In IDLE with start high and out == 0, the block SHALL pulse done for one cycle and remain in IDLE.
REQ-018 In RUN the prescale counter SHALL increment each cycle; when it equals the latched divisor, it SHALL return to 0 and out SHALL decrement by 1 (a tick).
REQ-019 First decrement SHALL occur exactly divisor+1 cycles after the start edge; with prescale=0, out decrements every cycle.
REQ-020 On the tick that takes out from 1 to 0, done SHALL be high in the same cycle out first reads 0, and the state SHALL return to IDLE.
REQ-021 out SHALL never wrap below 0; no decrement occurs in IDLE or PAUSE.
REQ-022 In RUN with pause high (and no load), the state SHALL enter PAUSE; out and the prescale counter SHALL hold.
REQ-023 In PAUSE with pause low, the state SHALL return to RUN and the prescale counter SHALL resume from its held value.
REQ-024 start in RUN or PAUSE SHALL be ignored; changes to prescale after start SHALL have no effect until the next start.
REQ-025 busy SHALL be a decode of the state register (RUN or PAUSE); done SHALL be high for one cycle per expiry only.

Reset
REQ-026 While reset_n is low, out = 0, state = IDLE, busy = 0, done = 0, and the prescale counter and divisor register = 0.
REQ-027 Reset asserted mid-RUN or mid-PAUSE SHALL abort without a done pulse.
REQ-028 After reset_n deasserts, the block SHALL act on inputs from the first posedge clk.

Verification
REQ-029 Reset, then load_val=3 with load, then start with prescale=0 -> out reads 3,2,1,0 on successive cycles; done high only with out=0; busy high for 3 cycles.
REQ-030 load_val=2, prescale=3, start -> out decrements after 4 and after 8 cycles; done pulses on the cycle out=0.
REQ-031 load_val=5, prescale=0, start, then pause high for 4 cycles at out=3 -> out holds 3 and busy stays 1; after pause drops, out reaches 0 three cycles later.
REQ-032 Counting from 10, assert load with load_val=7 mid-RUN -> out=7, state IDLE, busy=0, no done.
REQ-033 out=0 in IDLE, start -> single done pulse, busy stays 0, out stays 0; start and load both high -> load wins.
REQ-034 Drop reset_n asynchronously mid-RUN at out=4 -> out=0, busy=0, done=0 before the next clock edge.

Source files
------------

// File: rtl/always_ff_downtimer_if.sv
// Control/status bundle for the prescaled down-timer.
// The master drives the commands; the timer (slave) returns count, busy and done.
interface always_ff_downtimer_if #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [PRE_W-1:0] prescale;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, prescale, start, pause,
    input  out, busy, done
  );

  modport slave (
    input  load, load_val, prescale, start, pause,
    output out, busy, done
  );
endinterface

// File: rtl/always_ff_downtimer.sv
// Prescaled down-counter: loads a count, then decrements once per prescale+1
// cycles after start, pulsing done when it reaches zero.
//
// state | meaning
// IDLE  | count held; waiting for start or load
// RUN   | prescale counter advancing; count decrements on each tick
// PAUSE | count and prescale counter frozen while pause is high
module always_ff_downtimer #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input logic               clk,
  input logic               reset_n,
  always_ff_downtimer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [PRE_W-1:0] div;
  logic [PRE_W-1:0] pcnt;
  logic             done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      count  <= '0;
      div    <= '0;
      pcnt   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        count <= bus.load_val;
        state <= IDLE;
        pcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              if (count != '0) begin
                state <= RUN;
                div   <= bus.prescale;
                pcnt  <= '0;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          RUN, PAUSE: begin
            // Leaving PAUSE counts in the same cycle, so a pause of N cycles
            // delays expiry by exactly N cycles.
            if (bus.pause) begin
              state <= PAUSE;
            end else if (pcnt == div) begin
              pcnt  <= '0;
              count <= count - 1'b1;
              if (count == WIDTH'(1)) begin
                done_q <= 1'b1;
                state  <= IDLE;
              end else begin
                state <= RUN;
              end
            end else begin
              pcnt  <= pcnt + 1'b1;
              state <= RUN;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.out  = count;
  assign bus.busy = (state == RUN) || (state == PAUSE);
  assign bus.done = done_q;
endmodule

// File: tb/tb_always_ff_downtimer.sv
// Directed bench for always_ff_downtimer: a cycle-level reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_always_ff_downtimer;
  localparam int WIDTH = 8;
  localparam int PRE_W = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   check_en = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;

  always_ff_downtimer_if #(.WIDTH(WIDTH), .PRE_W(PRE_W)) bus ();

  always_ff_downtimer #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Reference model: count, whether a countdown is in progress, and the
  // number of unpaused cycles still to wait before the next decrement.
  int m_out = 0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_div = 0;
  int m_wait = 0;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_out = 0; m_busy = 1'b0; m_done = 1'b0; m_div = 0; m_wait = 0;
      end else begin
        m_done = 1'b0;
        if (bus.load) begin
          m_out  = int'(bus.load_val);
          m_busy = 1'b0;
        end else if (!m_busy) begin
          if (bus.start) begin
            if (m_out == 0) m_done = 1'b1;
            else begin
              m_busy = 1'b1;
              m_div  = int'(bus.prescale);
              m_wait = m_div + 1;
            end
          end
        end else if (!bus.pause) begin
          m_wait = m_wait - 1;
          if (m_wait == 0) begin
            m_out  = m_out - 1;
            m_wait = m_div + 1;
            if (m_out == 0) begin
              m_done = 1'b1;
              m_busy = 1'b0;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (check_en) begin
      vectors = vectors + 1;
      if (int'(bus.out) != m_out || bus.busy != m_busy || bus.done != m_done) begin
        miscompares = miscompares + 1;
        $display("FAIL model cycle %0d: got out=%0d busy=%0d done=%0d, want out=%0d busy=%0d done=%0d",
                 cyc, bus.out, bus.busy, bus.done, m_out, m_busy, m_done);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chk3(input string name, input int o, input int b, input int d);
    chk({name, ".out"},  int'(bus.out),  o);
    chk({name, ".busy"}, int'(bus.busy), b);
    chk({name, ".done"}, int'(bus.done), d);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit [13:0] pz;
    bus.load = 1'b0; bus.load_val = '0; bus.prescale = '0;
    bus.start = 1'b0; bus.pause = 1'b0;

    step(2);
    chk3("reset", 0, 0, 0);
    reset_n  = 1'b1;
    check_en = 1'b1;

    // load 3, start with prescale 0: 3,2,1,0
    bus.load = 1'b1; bus.load_val = 8'd3; step(1);
    chk3("p0_load", 3, 0, 0);
    bus.load = 1'b0; bus.start = 1'b1; bus.prescale = 4'd0; step(1);
    chk3("p0_run3", 3, 1, 0);
    bus.start = 1'b0; step(1);
    chk3("p0_run2", 2, 1, 0);
    step(1);
    chk3("p0_run1", 1, 1, 0);
    step(1);
    chk3("p0_expire", 0, 0, 1);
    step(1);
    chk3("p0_after", 0, 0, 0);

    // load 2, prescale 3; start and prescale changes during RUN are ignored
    bus.load = 1'b1; bus.load_val = 8'd2; step(1);
    bus.load = 1'b0; bus.start = 1'b1; bus.prescale = 4'd3; step(1);
    chk3("p3_start", 2, 1, 0);
    bus.prescale = 4'd0; step(2);
    bus.start = 1'b0; step(1);
    chk3("p3_edge3", 2, 1, 0);
    step(1);
    chk3("p3_edge4", 1, 1, 0);
    step(3);
    chk3("p3_edge7", 1, 1, 0);
    step(1);
    chk3("p3_edge8", 0, 0, 1);
    step(1);
    chk3("p3_after", 0, 0, 0);

    // load 5, pause for 4 cycles at out=3
    bus.load = 1'b1; bus.load_val = 8'd5; step(1);
    bus.load = 1'b0; bus.start = 1'b1; bus.prescale = 4'd0; step(1);
    bus.start = 1'b0; step(2);
    chk3("pz_at3", 3, 1, 0);
    bus.pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk3("pz_hold", 3, 1, 0);
    end
    bus.pause = 1'b0; step(2);
    chk3("pz_res1", 1, 1, 0);
    step(1);
    chk3("pz_end", 0, 0, 1);

    // load mid-RUN aborts without done
    bus.load = 1'b1; bus.load_val = 8'd10; step(1);
    bus.load = 1'b0; bus.start = 1'b1; bus.prescale = 4'd1; step(1);
    bus.start = 1'b0; step(4);
    chk3("ld_run8", 8, 1, 0);
    bus.load = 1'b1; bus.load_val = 8'd7; step(1);
    chk3("ld_abort", 7, 0, 0);
    bus.load = 1'b0; step(1);
    chk3("ld_idle", 7, 0, 0);

    // start with zero count, then start+load together
    bus.load = 1'b1; bus.load_val = 8'd0; step(1);
    bus.load = 1'b0; bus.start = 1'b1; step(1);
    chk3("z_start", 0, 0, 1);
    bus.start = 1'b0; step(1);
    chk3("z_after", 0, 0, 0);
    bus.start = 1'b1; bus.load = 1'b1; bus.load_val = 8'd6; step(1);
    chk3("z_loadwins", 6, 0, 0);
    bus.start = 1'b0; bus.load = 1'b0; step(1);

    // prescale 2 with an irregular pause pattern; the model checks each cycle
    bus.load = 1'b1; bus.load_val = 8'd3; step(1);
    bus.load = 1'b0; bus.start = 1'b1; bus.prescale = 4'd2; step(1);
    bus.start = 1'b0;
    pz = 14'b00110000011000;
    for (int i = 0; i < 14; i++) begin
      bus.pause = pz[i];
      step(1);
    end
    bus.pause = 1'b0;
    chk3("pp_end", 0, 0, 0);

    // asynchronous reset mid-RUN at out=4
    bus.load = 1'b1; bus.load_val = 8'd6; step(1);
    bus.load = 1'b0; bus.start = 1'b1; bus.prescale = 4'd0; step(1);
    bus.start = 1'b0; step(2);
    chk3("ar_at4", 4, 1, 0);
    #2 reset_n = 1'b0;
    #1 chk3("ar_async", 0, 0, 0);
    step(2);
    chk3("ar_held", 0, 0, 0);
    reset_n = 1'b1; bus.load = 1'b1; bus.load_val = 8'd9; step(1);
    chk3("ar_first", 9, 0, 0);
    bus.load = 1'b0; step(1);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
